// File: rtl/calc_pkg.sv
// Shared constants, FSM encoding and op decode for the calculator front-end.
package calc_pkg;

  localparam int unsigned BTN_W    = 5;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned RESULT_W = 9;
  localparam int unsigned BTN_CLR  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;
  localparam logic [OP_W-1:0] OP_MULT = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0001;

  localparam logic [RESULT_W-1:0] DIVZ_RESULT = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_EXEC    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Map a single debounced op button {U,R,D,L} to the ALU one-hot op.
  function automatic logic [OP_W-1:0] btn_to_op(input logic [OP_W-1:0] b);
    case (b)
      4'b1000: btn_to_op = OP_ADD;
      4'b0100: btn_to_op = OP_SUB;
      4'b0010: btn_to_op = OP_MULT;
      4'b0001: btn_to_op = OP_DIV;
      default: btn_to_op = '0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for the button vector.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned W               = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_btn_db
);

  logic [W-1:0]     r_meta;
  logic [W-1:0]     r_sync;
  logic [W-1:0]     r_cand;
  logic [W-1:0]     r_db;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, then accept a candidate vector once it has held for the full count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_cand <= '0;
      r_db   <= '0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      if (r_sync != r_cand) begin
        r_cand <= r_sync;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db <= r_cand;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_btn_db = r_db;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: one debounced press issues one ALU op and commits its result.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DP_LATENCY      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BTN_W-1:0]    btn,
  input  logic [DATA_W-1:0]   sw_a,
  input  logic [DATA_W-1:0]   sw_b,
  output logic [DATA_W-1:0]   dp_a,
  output logic [DATA_W-1:0]   dp_b,
  output logic [OP_W-1:0]     dp_op,
  input  logic [RESULT_W-1:0] dp_result,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                err
);

  localparam int unsigned LAT_W = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

  logic [BTN_W-1:0]    w_btn_db;
  logic                w_clr;
  logic [OP_W-1:0]     w_ops;
  logic                w_op_one;
  logic                w_op_any;

  state_t              r_state;
  logic [OP_W-1:0]     r_op_sel;
  logic [LAT_W-1:0]    r_lat;
  logic [DATA_W-1:0]   r_dp_a;
  logic [DATA_W-1:0]   r_dp_b;
  logic [OP_W-1:0]     r_dp_op;
  logic [RESULT_W-1:0] r_result;
  logic                r_result_valid;
  logic                r_busy;
  logic                r_err;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .W               (BTN_W)
  ) u_btn_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_btn    (btn),
    .o_btn_db (w_btn_db)
  );

  assign w_clr    = w_btn_db[BTN_CLR];
  assign w_ops    = w_btn_db[OP_W-1:0];
  assign w_op_one = $onehot(w_ops);
  assign w_op_any = |w_ops;

  // Sequencer FSM with registered datapath controls; clear overrides every state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_op_sel       <= '0;
      r_lat          <= '0;
      r_dp_a         <= '0;
      r_dp_b         <= '0;
      r_dp_op        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_clr) begin
        r_result <= '0;
        r_err    <= 1'b0;
        r_dp_op  <= '0;
        r_dp_a   <= '0;
        r_dp_b   <= '0;
        r_state  <= ST_RELEASE;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_op_one) begin
              r_op_sel <= btn_to_op(w_ops);
              r_state  <= ST_CAPTURE;
              r_busy   <= 1'b1;
            end else if (w_op_any) begin
              r_err   <= 1'b1;
              r_state <= ST_RELEASE;
              r_busy  <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            r_dp_a <= sw_a;
            r_dp_b <= sw_b;
            // Divide-by-zero never reaches the ALU; commit the sentinel directly.
            if ((r_op_sel == OP_DIV) && (sw_b == '0)) begin
              r_result       <= DIVZ_RESULT;
              r_err          <= 1'b1;
              r_result_valid <= 1'b1;
              r_state        <= ST_RELEASE;
            end else begin
              r_dp_op <= r_op_sel;
              r_lat   <= '0;
              r_state <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (r_lat == LAT_W'(DP_LATENCY - 1)) begin
              r_result       <= dp_result;
              r_result_valid <= 1'b1;
              r_dp_op        <= '0;
              r_state        <= ST_COMMIT;
            end else begin
              r_lat <= r_lat + LAT_W'(1);
            end
          end
          ST_COMMIT: begin
            r_state <= ST_RELEASE;
          end
          ST_RELEASE: begin
            if (w_btn_db == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dp_a         = r_dp_a;
  assign dp_b         = r_dp_b;
  assign dp_op        = r_dp_op;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer with a behavioural ALU and op model.
module tb_calc_op_sequencer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LAT  = 1;
  localparam int unsigned DEB3 = 1;
  localparam int unsigned LAT3 = 3;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_L = 5'b00001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] btn, btn3;
  logic [7:0] sw_a, sw_b;
  logic [7:0] dp_a, dp_b, dp_a3, dp_b3;
  logic [3:0] dp_op, dp_op3;
  logic [8:0] dp_result, dp_result3, result, result3;
  logic       result_valid, busy, err;
  logic       result_valid3, busy3, err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: ADD carry, SUB wrap, MULT low bits, DIV quotient.
  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b1000: return 9'(a) + 9'(b);
      4'b0100: return 9'(a) - 9'(b);
      4'b0010: return 9'(16'(a) * 16'(b));
      4'b0001: return (b == 8'd0) ? 9'h1FF : 9'(a / b);
      default: return 9'h000;
    endcase
  endfunction

  assign dp_result  = alu(dp_op, dp_a, dp_b);
  assign dp_result3 = alu(dp_op3, dp_a3, dp_b3);

  calc_op_sequencer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20), .DP_LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .sw_a(sw_a), .sw_b(sw_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_result(dp_result),
    .result(result), .result_valid(result_valid), .busy(busy), .err(err)
  );

  calc_op_sequencer #(.DEBOUNCE_CYCLES(DEB3), .CNT_W(20), .DP_LATENCY(LAT3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .btn(btn3), .sw_a(sw_a), .sw_b(sw_b),
    .dp_a(dp_a3), .dp_b(dp_b3), .dp_op(dp_op3), .dp_result(dp_result3),
    .result(result3), .result_valid(result_valid3), .busy(busy3), .err(err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected transactions for the main instance, in press order.
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       issue;
    logic [8:0] val;
    logic       err;
  } exp_t;

  exp_t q[$];
  logic m_err = 1'b0;

  task automatic expect_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.op    = op;
    e.a     = a;
    e.b     = b;
    e.issue = !((op == 4'b0001) && (b == 8'd0));
    e.val   = alu(op, a, b);
    if (!e.issue) m_err = 1'b1;
    e.err   = m_err;
    q.push_back(e);
  endtask

  // Main-instance compare process and latency bookkeeping.
  int   cyc = 0, t_busy = 0, t_op = 0, lat_op = -1, lat_cap = -1, n_pulse = 0;
  logic prev_valid = 1'b0, prev_busy = 1'b0, prev_op = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (busy && !prev_busy) t_busy = cyc;
      if ((dp_op != 4'd0) && !prev_op) t_op = cyc;
      if (dp_op != 4'd0) begin
        if (q.size() == 0) check("dp_op_unexpected", 32'(dp_op), 32'd0);
        else begin
          check("dp_op", 32'(dp_op), q[0].issue ? 32'(q[0].op) : 32'd0);
          check("dp_a", 32'(dp_a), 32'(q[0].a));
          check("dp_b", 32'(dp_b), 32'(q[0].b));
        end
      end
      if (result_valid) begin
        n_pulse++;
        lat_op  = cyc - t_op;
        lat_cap = cyc - t_busy;
        check("valid_single_cycle", 32'(prev_valid), 32'd0);
        if (q.size() == 0) check("valid_unexpected", 32'(result_valid), 32'd0);
        else begin
          check("result_at_valid", 32'(result), 32'(q[0].val));
          check("err_at_valid", 32'(err), 32'(q[0].err));
          void'(q.pop_front());
        end
      end
      prev_valid = result_valid;
      prev_busy  = busy;
      prev_op    = (dp_op != 4'd0);
    end
  end

  // Second instance: pulse count, op observation, op-to-valid latency.
  int   cyc3 = 0, t_op3 = 0, lat3 = -1, n_pulse3 = 0;
  logic saw_op3 = 1'b0, prev_op3 = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      cyc3++;
      if ((dp_op3 != 4'd0) && !prev_op3) t_op3 = cyc3;
      if (dp_op3 != 4'd0) saw_op3 = 1'b1;
      if (result_valid3) begin
        n_pulse3++;
        lat3 = cyc3 - t_op3;
      end
      prev_op3 = (dp_op3 != 4'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 80) begin
      @(negedge clk);
      k++;
    end
    check({name, "_return_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle3(input string name);
    int k = 0;
    while (busy3 && k < 80) begin
      @(negedge clk);
      k++;
    end
    check({name, "_return_idle"}, 32'(busy3), 32'd0);
  endtask

  task automatic press(input logic [4:0] b, input logic [7:0] a, input logic [7:0] bb, input int hold);
    sw_a = a;
    sw_b = bb;
    btn  = b;
    tick(hold);
    btn  = 5'd0;
    wait_idle("press");
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int   p0, p3;
  logic bounce_busy;

  initial begin
    reset_n = 1'b0;
    btn     = B_U;
    btn3    = B_U;
    sw_a    = 8'd0;
    sw_b    = 8'd0;
    tick(3);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dp_op", 32'(dp_op), 32'd0);
    check("rst_dp_a", 32'(dp_a), 32'd0);
    check("rst_dp_b", 32'(dp_b), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    btn  = 5'd0;
    btn3 = 5'd0;
    tick(2);
    reset_n = 1'b1;
    tick(4);

    // Pin the model against hand-computed values.
    check("model_add", 32'(alu(4'b1000, 8'd200, 8'd100)), 32'd300);
    check("model_sub", 32'(alu(4'b0100, 8'd5, 8'd10)), 32'h1FB);
    check("model_mult", 32'(alu(4'b0010, 8'd15, 8'd17)), 32'd255);
    check("model_div", 32'(alu(4'b0001, 8'd200, 8'd7)), 32'd28);

    // ADD held for 20 cycles, switches change after capture.
    p0 = n_pulse;
    expect_op(4'b1000, 8'd200, 8'd100);
    sw_a = 8'd200;
    sw_b = 8'd100;
    btn  = B_U;
    tick(12);
    sw_a = 8'd1;
    sw_b = 8'd1;
    tick(6);
    check("add_busy_while_held", 32'(busy), 32'd1);
    tick(2);
    btn = 5'd0;
    wait_idle("add");
    tick(2);
    check("add_pulses", 32'(n_pulse - p0), 32'd1);
    check("add_result", 32'(result), 32'd300);
    check("add_err", 32'(err), 32'd0);
    check("add_lat_op_to_valid", 32'(lat_op), 32'(LAT));
    check("add_lat_capture_to_valid", 32'(lat_cap), 32'(LAT + 1));

    p0 = n_pulse;
    expect_op(4'b0100, 8'd5, 8'd10);
    press(B_R, 8'd5, 8'd10, 10);
    check("sub_result", 32'(result), 32'h1FB);
    check("sub_pulses", 32'(n_pulse - p0), 32'd1);

    p0 = n_pulse;
    expect_op(4'b0010, 8'd15, 8'd17);
    press(B_D, 8'd15, 8'd17, 10);
    check("mult_result", 32'(result), 32'd255);
    check("mult_pulses", 32'(n_pulse - p0), 32'd1);

    p0 = n_pulse;
    expect_op(4'b0001, 8'd200, 8'd7);
    press(B_L, 8'd200, 8'd7, 10);
    check("div_result", 32'(result), 32'd28);
    check("div_pulses", 32'(n_pulse - p0), 32'd1);

    p0 = n_pulse;
    expect_op(4'b0001, 8'd9, 8'd0);
    press(B_L, 8'd9, 8'd0, 10);
    check("divz_result", 32'(result), 32'h1FF);
    check("divz_err", 32'(err), 32'd1);
    check("divz_pulses", 32'(n_pulse - p0), 32'd1);

    p0 = n_pulse;
    press(B_C, 8'd0, 8'd0, 10);
    m_err = 1'b0;
    check("clr_result", 32'(result), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    check("clr_pulses", 32'(n_pulse - p0), 32'd0);

    // Bouncing U never reaches a stable count.
    p0 = n_pulse;
    bounce_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0) ? B_U : 5'd0;
      repeat (2) begin
        @(negedge clk);
        bounce_busy = bounce_busy | busy;
      end
    end
    btn = 5'd0;
    repeat (12) begin
      @(negedge clk);
      bounce_busy = bounce_busy | busy;
    end
    check("bounce_no_busy", 32'(bounce_busy), 32'd0);
    check("bounce_pulses", 32'(n_pulse - p0), 32'd0);

    p0 = n_pulse;
    press(B_U | B_R, 8'd3, 8'd4, 10);
    check("multi_err", 32'(err), 32'd1);
    check("multi_pulses", 32'(n_pulse - p0), 32'd0);
    check("multi_result_kept", 32'(result), 32'd0);

    press(B_C | B_U, 8'd0, 8'd0, 10);
    check("clr_op_err", 32'(err), 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);

    // Second instance: DP_LATENCY=3, one-sample debounce.
    sw_a = 8'd200;
    sw_b = 8'd100;
    btn3 = B_U;
    tick(6);
    btn3 = 5'd0;
    wait_idle3("i3_add");
    tick(2);
    check("i3_add_result", 32'(result3), 32'd300);
    check("i3_add_pulses", 32'(n_pulse3), 32'd1);
    check("i3_lat_op_to_valid", 32'(lat3), 32'(LAT3));

    btn3 = B_U | B_R;
    tick(4);
    btn3 = 5'd0;
    wait_idle3("i3_multi");
    tick(2);
    check("i3_multi_err", 32'(err3), 32'd1);

    // Clear lands while the MULT is in EXEC.
    p3      = n_pulse3;
    sw_a    = 8'd15;
    sw_b    = 8'd17;
    saw_op3 = 1'b0;
    btn3    = B_D;
    tick(2);
    btn3 = B_C | B_D;
    tick(8);
    check("i3_clr_saw_exec", 32'(saw_op3), 32'd1);
    check("i3_clr_no_pulse", 32'(n_pulse3 - p3), 32'd0);
    check("i3_clr_result", 32'(result3), 32'd0);
    check("i3_clr_err", 32'(err3), 32'd0);
    check("i3_clr_dp_op", 32'(dp_op3), 32'd0);
    check("i3_clr_dp_a", 32'(dp_a3), 32'd0);
    check("i3_clr_busy_held", 32'(busy3), 32'd1);
    btn3 = B_D;
    tick(6);
    check("i3_release_wait", 32'(busy3), 32'd1);
    btn3 = 5'd0;
    wait_idle3("i3_release");
    tick(4);
    check("i3_final_pulses", 32'(n_pulse3 - p3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
